// File: rtl/counter_pkg.sv
// Shared constants and types for the free-running counter.
//   COUNT_WIDTH : default counter width in bits (4)
//   count_t     : counter value type at the default width
package counter_pkg;

  localparam int COUNT_WIDTH = 4;

  typedef logic [COUNT_WIDTH-1:0] count_t;

endpackage : counter_pkg

// File: rtl/counter_4bit.sv
// Free-running up-counter with synchronous parallel load.
//
// Ports:
//   clk       : single clock, all state changes on its rising edge except reset
//   reset_n   : asynchronous active-low reset, clears count immediately
//   load      : synchronous load enable, active-high, takes priority over counting
//   load_data : value captured into the counter on a rising edge while load is high
//   count     : counter value, driven straight from the register
//
// Priority is reset, then load, then increment. The counter has no enable and
// wraps silently from all-ones back to zero. Reset release is assumed to be
// synchronised upstream, so no synchroniser is included here.
module counter_4bit #(
  parameter int WIDTH = counter_pkg::COUNT_WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q <= '0;
    end else if (load) begin
      count_q <= load_data;
    end else begin
      // Natural modulo-2^WIDTH wrap; no flag, no stall.
      count_q <= count_q + WIDTH'(1);
    end
  end

  assign count = count_q;

endmodule : counter_4bit

// File: tb/tb_counter_4bit.sv
module tb_counter_4bit;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  logic         clk;
  logic         reset_n;
  logic         load;
  logic [W-1:0] load_data;
  logic [W-1:0] count;

  int checks = 0;
  int errors = 0;
  int exp_count = 0;
  bit chk_en = 1'b0;

  counter_4bit #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .load      (load),
    .load_data (load_data),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: count=%0d expected=%0d at t=%0t", name, act, req, $time);
    end
  endtask

  // Every negative edge: DUT output must match the behavioural model.
  always @(negedge clk) begin
    if (chk_en) check("model", int'(count), exp_count);
  end

  // One clock cycle of stimulus. Model: reset holds 0; load takes the value
  // sampled at the edge; otherwise add one modulo 2^W. load_data is scrambled
  // right after the edge to show mid-cycle changes are ignored.
  task automatic cyc(input logic l, input logic [W-1:0] d);
    load = l;
    load_data = d;
    @(posedge clk);
    if (reset_n) exp_count = l ? int'(d) : (exp_count + 1) % MOD;
    #1 load_data = W'($urandom);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b1;
    load      = 1'b0;
    load_data = '0;

    // Reset asserted away from any edge clears count without a clock.
    #2 reset_n = 1'b0;
    exp_count = 0;
    #1 check("rst_immediate", int'(count), 0);
    chk_en = 1'b1;
    @(negedge clk);
    check("rst_hold_edge1", int'(count), 0);
    cyc(1'b1, 4'd7);
    check("rst_hold_edge2", int'(count), 0);

    // Release and count up.
    reset_n = 1'b1;
    cyc(1'b0, 4'd0); check("count_1", int'(count), 1);
    cyc(1'b0, 4'd0); check("count_2", int'(count), 2);
    cyc(1'b0, 4'd0); check("count_3", int'(count), 3);
    cyc(1'b0, 4'd0); check("count_4", int'(count), 4);
    cyc(1'b0, 4'd0); check("count_5", int'(count), 5);

    // Load held for two cycles, then counting resumes from load_data+1.
    cyc(1'b1, 4'd3); check("load_hold_1", int'(count), 3);
    cyc(1'b1, 4'd3); check("load_hold_2", int'(count), 3);
    cyc(1'b0, 4'd0); check("load_resume_4", int'(count), 4);
    cyc(1'b0, 4'd0); check("load_resume_5", int'(count), 5);

    // Wrap from 14.
    cyc(1'b1, 4'd14); check("wrap_load14", int'(count), 14);
    cyc(1'b0, 4'd0);  check("wrap_15", int'(count), 15);
    cyc(1'b0, 4'd0);  check("wrap_0", int'(count), 0);
    cyc(1'b0, 4'd0);  check("wrap_1", int'(count), 1);

    // Load 15 then release.
    cyc(1'b1, 4'd15); check("load15", int'(count), 15);
    cyc(1'b0, 4'd0);  check("load15_wrap0", int'(count), 0);

    // Async reset pulse between edges at count=9.
    cyc(1'b1, 4'd8);  check("pre_9_load8", int'(count), 8);
    cyc(1'b0, 4'd0);  check("pre_9", int'(count), 9);
    #2 reset_n = 1'b0;
    exp_count = 0;
    #1 check("mid_rst_zero", int'(count), 0);
    #1 reset_n = 1'b1;
    cyc(1'b0, 4'd0);  check("mid_rst_then_1", int'(count), 1);

    // Load while in reset is ignored; first edge after release loads.
    #1 reset_n = 1'b0;
    exp_count = 0;
    cyc(1'b1, 4'd10); check("conflict_rst_0a", int'(count), 0);
    cyc(1'b1, 4'd10); check("conflict_rst_0b", int'(count), 0);
    reset_n = 1'b1;
    cyc(1'b1, 4'd10); check("conflict_load10", int'(count), 10);
    cyc(1'b0, 4'd0);  check("conflict_then_11", int'(count), 11);

    // Randomised traffic with occasional async reset pulses between edges.
    for (int i = 0; i < 400; i++) begin
      logic         l;
      logic [W-1:0] d;
      l = ($urandom_range(0, 3) == 0);
      d = W'($urandom);
      if ($urandom_range(0, 24) == 0) begin
        #1 reset_n = 1'b0;
        exp_count = 0;
        #1 check("rand_rst_zero", int'(count), 0);
        #($urandom_range(1, 2)) reset_n = 1'b1;
      end
      cyc(l, d);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_counter_4bit

// File: doc/counter_4bit.md
COUNTER_4BIT -- requirements
Module: counter_4bit

Interface
REQ-001 Parameter: WIDTH, default 4, counter width in bits; all requirements below are stated for the default.
REQ-002 clk  input  1  single clock; all state changes on its rising edge except reset.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 load  input  1  synchronous parallel-load enable, active-high.
REQ-005 load_data  input  WIDTH  value captured into the counter when load is high.
REQ-006 count  output  WIDTH  current counter value, driven directly from the register with no combinational path from inputs.

Function
REQ-007 The block SHALL hold one WIDTH-bit register whose value is count.
REQ-008 Priority SHALL be reset_n low, then load high, then increment.
REQ-009 On a rising clk edge with reset_n high and load high, count SHALL become load_data, with 1-cycle latency.
REQ-010 On a rising clk edge with reset_n high and load low, count SHALL become count+1 modulo 2^WIDTH.
REQ-011 The counter SHALL count unconditionally; there is no enable input.
REQ-012 Wrap-around SHALL be silent: 15 -> 0, with no flag and no stall.
REQ-013 If load is held high for N cycles, count SHALL equal load_data after each of those edges.
REQ-014 Counting SHALL resume from load_data+1 on the first edge after load drops.
REQ-015 load with load_data=15 SHALL give 15, then 0 on the next increment.
REQ-016 load_data SHALL be sampled only at the clock edge; changes between edges SHALL have no effect.
REQ-017 load and load_data SHALL be ignored while reset_n is low.
REQ-018 X or Z on load SHALL NOT be given defined behaviour; the bench SHALL drive known values after reset.

Reset
REQ-019 When reset_n goes low, count SHALL become 0 immediately, without waiting for a clk edge.
REQ-020 count SHALL stay 0 for as long as reset_n is low, regardless of clk and load.
REQ-021 Reset asserted mid-count SHALL discard the current value.
REQ-022 On the first rising edge after reset_n rises, the normal priority SHALL apply: count becomes 1, or load_data if load is high.
REQ-023 Reset deassertion is assumed synchronous to clk upstream; no internal synchronizer SHALL be included.

Structure
REQ-024 A shared package counter_pkg SHALL hold the WIDTH default constant (4) and a count_t typedef (logic [WIDTH-1:0]).
REQ-025 The design SHALL be a single flat module with one sequential process; no sub-module is required.
REQ-026 The module SHALL be synthesizable, with no latches and no initial values used in place of reset.

Verification
REQ-027 Reset: drive reset_n=0 at any time relative to clk -> count=0 immediately, and count stays 0 across at least 2 clk edges.
REQ-028 Count-up: release reset_n with load=0 -> count reads 1, 2, 3, ... on successive rising edges.
REQ-029 Load hold: at count=5, drive load=1 with load_data=3 for 2 cycles -> count=3, 3; then load=0 -> count=4, 5.
REQ-030 Wrap: let count run from 14 -> count reads 15, 0, 1; also load_data=15 then release load -> 15, 0.
REQ-031 Async reset mid-operation: pulse reset_n low between clk edges at count=9 -> count=0 before the next edge; after release -> 1.
REQ-032 Load/reset conflict: load=1, load_data=10 while reset_n=0 -> count stays 0; after reset_n rises with load still high -> count=10 on the next edge.
